// File: rtl/gate_netlist_eval.sv
// ============================================================================
// Module      : gate_netlist_eval
// Description : Cycle-level evaluator for genetic-gate mapped netlists
//               (NOT/NOR/DLATCH/DFF/SR) with frame commit of outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_netlist_eval #(
    parameter int AW  = 4,
    parameter int NPI = 8,
    parameter int NPO = 8
) (
    input  logic                  C,
    input  logic                  RN,
    input  logic [4+3*AW-1:0]     ins_data,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [NPI-1:0]        pi,
    output logic [NPO-1:0]        po,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic                  err
);

    localparam int NNETS = 2 ** AW;
    localparam int IW    = 4 + 3 * AW;
    localparam int PIW   = (NPI > 1) ? $clog2(NPI) : 1;
    localparam int POW   = (NPO > 1) ? $clog2(NPO) : 1;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_NOT    = 4'd1;
    localparam logic [3:0] OP_NOR    = 4'd2;
    localparam logic [3:0] OP_DLATCH = 4'd3;
    localparam logic [3:0] OP_DFF    = 4'd4;
    localparam logic [3:0] OP_SR     = 4'd5;
    localparam logic [3:0] OP_LOAD   = 4'd6;
    localparam logic [3:0] OP_STORE  = 4'd7;
    localparam logic [3:0] OP_END    = 4'd15;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t               state;
    logic [NNETS-1:0]     net;
    logic [NNETS-1:0]     prev;
    logic [NPO-1:0]       po_sh;

    // Instruction field decode
    logic [3:0]           op;
    logic [AW-1:0]        dst;
    logic [AW-1:0]        src_a;
    logic [AW-1:0]        src_b;
    logic [PIW-1:0]       pi_idx;
    logic [POW-1:0]       po_idx;

    assign op     = ins_data[IW-1 -: 4];
    assign dst    = ins_data[3*AW-1 -: AW];
    assign src_a  = ins_data[2*AW-1 -: AW];
    assign src_b  = ins_data[AW-1:0];
    assign pi_idx = PIW'(32'(src_a) % NPI);
    assign po_idx = POW'(32'(dst) % NPO);

    logic                 accept;
    logic                 val_a;
    logic                 val_b;
    logic                 prev_b;

    assign accept = ins_valid && ins_ready;
    assign val_a  = net[src_a];
    assign val_b  = net[src_b];
    assign prev_b = prev[src_b];

    // Per-instruction effect: at most one net write, one shadow write
    logic                 net_we;
    logic                 net_wd;
    logic                 sh_we;
    logic                 end_seen;
    logic                 bad_op;

    always_comb begin
        net_we   = 1'b0;
        net_wd   = 1'b0;
        sh_we    = 1'b0;
        end_seen = 1'b0;
        bad_op   = 1'b0;
        if (accept) begin
            case (op)
                OP_NOP: begin
                end
                OP_NOT: begin
                    net_we = 1'b1;
                    net_wd = ~val_a;
                end
                OP_NOR: begin
                    net_we = 1'b1;
                    net_wd = ~(val_a | val_b);
                end
                OP_DLATCH: begin
                    net_we = val_b;
                    net_wd = val_a;
                end
                OP_DFF: begin
                    // Edge is measured against the snapshot of the last commit,
                    // so every DFF on the same clock net agrees within a frame.
                    net_we = ~prev_b & val_b;
                    net_wd = val_a;
                end
                OP_SR: begin
                    // Reset dominates when both S and R are asserted
                    if (val_b) begin
                        net_we = 1'b1;
                        net_wd = 1'b0;
                    end else if (val_a) begin
                        net_we = 1'b1;
                        net_wd = 1'b1;
                    end
                end
                OP_LOAD: begin
                    net_we = 1'b1;
                    net_wd = pi[pi_idx];
                end
                OP_STORE: begin
                    sh_we = 1'b1;
                end
                OP_END: begin
                    end_seen = 1'b1;
                end
                default: begin
                    bad_op = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state     <= RUN;
            net       <= '0;
            prev      <= '0;
            po_sh     <= '0;
            po        <= '0;
            frame_cnt <= 16'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            ins_ready <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (net_we) begin
                        net[dst] <= net_wd;
                    end
                    if (sh_we) begin
                        po_sh[po_idx] <= val_a;
                    end
                    if (bad_op) begin
                        err <= 1'b1;
                    end
                    if (end_seen) begin
                        state     <= COMMIT;
                        ins_ready <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                COMMIT: begin
                    po        <= po_sh;
                    prev      <= net;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= RUN;
                    ins_ready <= 1'b1;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    ins_ready <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_netlist_eval.sv
// ============================================================================
// Module      : tb_gate_netlist_eval
// Description : Scoreboarded random + directed bench for gate_netlist_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_netlist_eval;

    localparam int AW  = 4;
    localparam int NPI = 8;
    localparam int NPO = 8;

    logic             C;
    logic             RN;
    logic [15:0]      ins_data;
    logic             ins_valid;
    logic             ins_ready;
    logic [7:0]       pi;
    logic [7:0]       po;
    logic             done;
    logic [15:0]      frame_cnt;
    logic             err;

    gate_netlist_eval #(.AW(AW), .NPI(NPI), .NPO(NPO)) dut (
        .C         (C),
        .RN        (RN),
        .ins_data  (ins_data),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pi        (pi),
        .po        (po),
        .done      (done),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int checks;
    int fails;
    int last_wait;

    typedef struct {
        logic [7:0]  po;
        logic [15:0] fc;
        logic        err;
    } exp_t;

    exp_t q[$];

    // Reference model: plain bit arrays evaluated one instruction at a time
    bit   m_net[16];
    bit   m_prev[16];
    bit   m_posh[8];
    bit   m_po[8];
    int   m_fc;
    bit   m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_net[i]  = 0;
            m_prev[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            m_posh[i] = 0;
            m_po[i]   = 0;
        end
        m_fc  = 0;
        m_err = 0;
        q.delete();
    endtask

    task automatic model_exec(input int op, input int d, input int a, input int b, input logic [7:0] piv);
        exp_t e;
        bit   sa;
        bit   sb;
        sa = m_net[a];
        sb = m_net[b];
        case (op)
            0: ;
            1: m_net[d] = !sa;
            2: m_net[d] = !(sa || sb);
            3: if (sb) m_net[d] = sa;
            4: if (!m_prev[b] && sb) m_net[d] = sa;
            5: begin
                if (sb)      m_net[d] = 0;
                else if (sa) m_net[d] = 1;
            end
            6: m_net[d] = piv[a % NPI];
            7: m_posh[d % NPO] = sa;
            15: begin
                for (int i = 0; i < 16; i++) m_prev[i] = m_net[i];
                for (int i = 0; i < 8; i++)  m_po[i]   = m_posh[i];
                m_fc = (m_fc + 1) % 65536;
                for (int i = 0; i < 8; i++) e.po[i] = m_po[i];
                e.fc  = 16'(m_fc);
                e.err = m_err;
                q.push_back(e);
            end
            default: m_err = 1;
        endcase
    endtask

    // Present one word, hold until accepted, update the model on acceptance
    task automatic send(input int op, input int d, input int a, input int b, input logic [7:0] piv);
        int w;
        w = 0;
        @(negedge C);
        ins_data  = {4'(op), 4'(d), 4'(a), 4'(b)};
        pi        = piv;
        ins_valid = 1'b1;
        while (!ins_ready && w < 20) begin
            @(negedge C);
            w++;
        end
        last_wait = w;
        if (!ins_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: ins_ready=%0b after %0d cycles, expected 1", ins_ready, w);
            ins_valid = 1'b0;
        end else begin
            model_exec(op, d, a, b, piv);
            @(posedge C);
        end
    endtask

    task automatic idle(input int n);
        @(negedge C);
        ins_valid = 1'b0;
        repeat (n - 1) @(negedge C);
    endtask

    // End a frame and return just after the commit edge
    task automatic end_frame();
        send(15, 0, 0, 0, 8'h00);
        @(posedge C);
        #1;
    endtask

    // Monitor: every done pulse pops one expected frame result
    initial begin
        exp_t e;
        forever begin
            @(negedge C);
            if (done === 1'b1) begin
                chk("ready_low_in_commit", 32'(ins_ready), 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 with no frame pending, expected 0");
                end else begin
                    e = q.pop_front();
                    @(posedge C);
                    #1;
                    chk("commit_po", 32'(po), 32'(e.po));
                    chk("commit_frame_cnt", 32'(frame_cnt), 32'(e.fc));
                    chk("commit_err", 32'(err), 32'(e.err));
                end
                @(negedge C);
                chk("done_one_cycle", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        int op;
        int n;
        checks    = 0;
        fails     = 0;
        last_wait = 0;
        RN        = 1'b0;
        ins_valid = 1'b0;
        ins_data  = '0;
        pi        = '0;
        model_reset();
        repeat (3) @(negedge C);
        RN = 1'b1;
        @(negedge C);
        chk("reset_po", 32'(po), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_ready", 32'(ins_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);

        // NOR / NOT truth
        for (int k = 0; k < 2; k++) begin
            logic [7:0] p;
            p = (k == 0) ? 8'b00 : 8'b10;
            send(6, 1, 0, 0, p);
            send(6, 2, 1, 0, p);
            send(2, 3, 1, 2, p);
            send(1, 4, 3, 0, p);
            send(7, 0, 3, 0, p);
            send(7, 1, 4, 0, p);
            end_frame();
            chk("nor_not_po", 32'(po[1:0]), (k == 0) ? 32'b01 : 32'b10);
            chk("nor_not_cnt", 32'(frame_cnt), 32'(k + 1));
        end

        // DLATCH: pi[0]=D, pi[1]=E
        for (int k = 0; k < 3; k++) begin
            logic [7:0] p;
            p = (k == 0) ? 8'b11 : (k == 1) ? 8'b00 : 8'b10;
            send(6, 8, 0, 0, p);
            send(6, 9, 1, 0, p);
            send(3, 10, 8, 9, p);
            send(7, 3, 10, 0, p);
            end_frame();
            chk("dlatch_q", 32'(po[3]), (k == 2) ? 32'd0 : 32'd1);
        end

        // DFF: pi[0]=clk, pi[1]=D; second DFF on same clock sees same edge
        for (int k = 0; k < 3; k++) begin
            logic [7:0] p;
            p = (k == 0) ? 8'b00 : (k == 1) ? 8'b11 : 8'b01;
            send(6, 11, 0, 0, p);
            send(6, 12, 1, 0, p);
            send(4, 13, 12, 11, p);
            send(4, 13, 12, 11, p);
            send(7, 4, 13, 0, p);
            end_frame();
            chk("dff_q", 32'(po[4]), (k == 0) ? 32'd0 : 32'd1);
        end

        // SR: pi[0]=S, pi[1]=R
        for (int k = 0; k < 4; k++) begin
            logic [7:0] p;
            p = (k == 0) ? 8'b01 : (k == 1) ? 8'b00 : (k == 2) ? 8'b11 : 8'b10;
            send(6, 14, 0, 0, p);
            send(6, 15, 1, 0, p);
            send(5, 6, 14, 15, p);
            send(7, 5, 6, 0, p);
            end_frame();
            chk("sr_q", 32'(po[5]), (k < 2) ? 32'd1 : 32'd0);
        end

        // Back-to-back END words with valid held high
        send(15, 0, 0, 0, 8'h00);
        send(15, 0, 0, 0, 8'h00);
        chk("b2b_end_stall", 32'(last_wait), 32'd1);
        send(15, 0, 0, 0, 8'h00);
        chk("b2b_end_stall", 32'(last_wait), 32'd1);
        send(0, 0, 0, 0, 8'h00);
        chk("b2b_end_stall", 32'(last_wait), 32'd1);
        idle(3);

        // Unknown opcode sets sticky err
        send(9, 1, 2, 3, 8'h00);
        end_frame();
        chk("err_set", 32'(err), 32'd1);
        end_frame();
        chk("err_sticky", 32'(err), 32'd1);
        idle(3);

        // Reset mid-frame
        send(6, 1, 0, 0, 8'hFF);
        send(7, 2, 1, 0, 8'hFF);
        send(7, 3, 1, 0, 8'hFF);
        #2;
        RN        = 1'b0;
        ins_valid = 1'b0;
        model_reset();
        #1;
        chk("midrst_po", 32'(po), 32'd0);
        chk("midrst_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        repeat (2) @(negedge C);
        RN = 1'b1;
        send(6, 1, 0, 0, 8'h01);
        send(7, 7, 1, 0, 8'h01);
        end_frame();
        chk("post_rst_po", 32'(po), 32'h80);
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(2, 14);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 99) < 3) op = $urandom_range(8, 14);
                else                           op = $urandom_range(0, 7);
                send(op, $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), 8'($urandom));
                if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 2));
            end
            send(15, 0, 0, 0, 8'($urandom));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end

        idle(6);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
